// File: rtl/marquee_pkg.sv
// marquee_pkg: letter codes, mode encodings and window geometry shared by the marquee blocks.
package marquee_pkg;
    localparam int MSG_LEN = 6;
    localparam int WIN_LEN = 4;
    localparam logic [3:0] L_P = 4'd0;
    localparam logic [3:0] L_L = 4'd1;
    localparam logic [3:0] L_A = 4'd2;
    localparam logic [3:0] L_Y = 4'd3;
    localparam logic [3:0] L_U = 4'd4;
    localparam logic [3:0] L_S = 4'd5;
    localparam logic [3:0] L_E = 4'd6;
    localparam logic [3:0] L_H = 4'd7;
    localparam logic [3:0] L_O = 4'd8;
    localparam logic [3:0] L_BLANK = 4'hF;
    typedef enum logic [1:0] {
        MODE_PLAY  = 2'd0,
        MODE_PAUSE = 2'd1,
        MODE_HELLO = 2'd2,
        MODE_BLANK = 2'd3
    } mode_e;
    // Inputs never exceed (MSG_LEN-1) + (WIN_LEN-1), so a single subtraction suffices.
    function automatic logic [2:0] mod6(input logic [3:0] v);
        return (v >= 4'd6) ? 3'(v - 4'd6) : v[2:0];
    endfunction
endpackage

// File: rtl/msg_rom.sv
// msg_rom: combinational (mode, index) to letter-code lookup for one display digit.
module msg_rom
    import marquee_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [2:0] idx,
    output logic [3:0] code
);
    // Index 0 sits in the low nibble; entries 6 and 7 pad the table to a power of two.
    localparam logic [31:0] MSG_PLAY  = {L_BLANK, L_BLANK, L_BLANK, L_BLANK, L_Y, L_A, L_L, L_P};
    localparam logic [31:0] MSG_PAUSE = {L_BLANK, L_BLANK, L_BLANK, L_E, L_S, L_U, L_A, L_P};
    localparam logic [31:0] MSG_HELLO = {L_BLANK, L_BLANK, L_BLANK, L_O, L_L, L_L, L_E, L_H};
    localparam logic [31:0] MSG_BLANK = {8{L_BLANK}};

    logic [31:0] msg;

    assign msg  = (mode == MODE_PLAY)  ? MSG_PLAY  :
                  (mode == MODE_PAUSE) ? MSG_PAUSE :
                  (mode == MODE_HELLO) ? MSG_HELLO : MSG_BLANK;
    assign code = msg[{idx, 2'b00} +: 4];
endmodule

// File: rtl/marquee_ctrl.sv
// marquee_ctrl: 4-digit status-message generator with optional right-to-left scrolling.
// Scrolling, freeze and wrap are enabled by defining MARQUEE_SCROLL_EN; otherwise every mode is static.
module marquee_ctrl
    import marquee_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       freeze,
    output logic [3:0] BCD3,
    output logic [3:0] BCD2,
    output logic [3:0] BCD1,
    output logic [3:0] BCD0,
    output logic       wrap
);
    logic [1:0] mode_q;
    logic [1:0] rom_mode;
    logic [2:0] base;
    logic       chg;
    logic [3:0] disp [WIN_LEN];
    logic [3:0] win  [WIN_LEN];

    assign chg = mode != mode_q;

`ifdef MARQUEE_SCROLL_EN
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    pos;
    logic [2:0]    pos_nx;
    logic          scroll;
    logic          step;

    assign pos_nx   = (pos == 3'(MSG_LEN - 1)) ? 3'd0 : pos + 3'd1;
    assign scroll   = (mode_q == MODE_PAUSE) || (mode_q == MODE_HELLO);
    assign step     = scroll && (cnt == LAST);
    // The ROMs look ahead: the new mode at window 0 on a change, else the next scroll window.
    assign rom_mode = chg ? mode : mode_q;
    assign base     = chg ? 3'd0 : pos_nx;
`else
    logic unused_freeze;

    assign unused_freeze = freeze;
    assign rom_mode      = mode;
    assign base          = 3'd0;
`endif

    for (genvar i = 0; i < WIN_LEN; i++) begin : g_dig
        logic [2:0] idx;
        assign idx = mod6({1'b0, base} + 4'(i));
        msg_rom u_rom (.mode(rom_mode), .idx(idx), .code(win[i]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_BLANK;
            disp   <= '{default: L_BLANK};
            wrap   <= 1'b0;
`ifdef MARQUEE_SCROLL_EN
            cnt    <= '0;
            pos    <= '0;
`endif
        end else if (chg) begin
            mode_q <= mode;
            disp   <= win;
            wrap   <= 1'b0;
`ifdef MARQUEE_SCROLL_EN
            cnt    <= '0;
            pos    <= '0;
        end else if (freeze) begin
            wrap   <= 1'b0;
        end else if (step) begin
            cnt    <= '0;
            pos    <= pos_nx;
            disp   <= win;
            wrap   <= pos_nx == 3'd0;
        end else begin
            cnt    <= scroll ? cnt + 1'b1 : '0;
            wrap   <= 1'b0;
`else
        end else begin
            wrap   <= 1'b0;
`endif
        end
    end

    assign BCD3 = disp[0];
    assign BCD2 = disp[1];
    assign BCD1 = disp[2];
    assign BCD0 = disp[3];
endmodule

// File: tb/tb_marquee_ctrl.sv
// tb_marquee_ctrl: directed checks of marquee_ctrl with TICK_DIV=4, covering the static build
// and, when MARQUEE_SCROLL_EN is defined, scrolling, freeze, mid-scroll mode change and reset.
module tb_marquee_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       freeze = 1'b0;
    logic [3:0] BCD3, BCD2, BCD1, BCD0;
    logic       wrap;
    int         errors = 0;
    int         checks = 0;

    localparam logic [15:0] W_PLAY = 16'h0123;
    localparam logic [15:0] W_HELL = 16'h7611;
    localparam logic [15:0] W_BLNK = 16'hFFFF;
    // PAUSE_ windows 0..5: PAUS AUSE USE_ SE_P E_PA _PAU
    localparam logic [15:0] W_PAUSE [6] = '{16'h0245, 16'h2456, 16'h456F, 16'h56F0, 16'h6F02, 16'hF024};

    marquee_ctrl #(.TICK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .freeze(freeze),
        .BCD3(BCD3), .BCD2(BCD2), .BCD1(BCD1), .BCD0(BCD0), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] exp_d, input logic exp_w);
        checks++;
        assert ({BCD3, BCD2, BCD1, BCD0} === exp_d && wrap === exp_w) else begin
            errors++;
            $error("FAIL %s: got disp=%h wrap=%b, want disp=%h wrap=%b",
                   tag, {BCD3, BCD2, BCD1, BCD0}, wrap, exp_d, exp_w);
        end
    endtask

    initial begin
        step(2);
        chk("reset_vals", W_BLNK, 1'b0);
        rst_n = 1'b1;
        step(1);
        chk("play_load", W_PLAY, 1'b0);
        for (int k = 0; k < 50; k++) begin
            step(1);
            chk("play_static", W_PLAY, 1'b0);
        end
`ifdef MARQUEE_SCROLL_EN
        mode = 2'd1;
        #1;
        chk("pause_latency", W_PLAY, 1'b0);
        step(1);
        chk("pause_load", W_PAUSE[0], 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(3);
            chk("scroll_hold", W_PAUSE[k - 1], 1'b0);
            step(1);
            chk("scroll_step", W_PAUSE[k % 6], k == 6);
        end
        step(1);
        chk("wrap_single", W_PAUSE[0], 1'b0);
        step(3);
        chk("to_ause", W_PAUSE[1], 1'b0);
        step(4);
        chk("to_use", W_PAUSE[2], 1'b0);
        step(2);
        freeze = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("freeze_hold", W_PAUSE[2], 1'b0);
        end
        freeze = 1'b0;
        step(1);
        chk("freeze_resume1", W_PAUSE[2], 1'b0);
        step(1);
        chk("freeze_resume2", W_PAUSE[3], 1'b0);
        step(3);
        chk("pending_step", W_PAUSE[3], 1'b0);
        mode = 2'd2;
        step(1);
        chk("chg_over_step", W_HELL, 1'b0);
        step(3);
        chk("chg_cnt_restart", W_HELL, 1'b0);
        step(1);
        chk("hello_step", 16'h6118, 1'b0);
        mode = 2'd1;
        step(1);
        chk("pause_reload", W_PAUSE[0], 1'b0);
        step(16);
        chk("to_epa", W_PAUSE[4], 1'b0);
        step(1);
        rst_n = 1'b0;
        #1;
        chk("async_reset", W_BLNK, 1'b0);
        step(2);
        chk("reset_held", W_BLNK, 1'b0);
        rst_n = 1'b1;
        step(1);
        chk("reset_reload", W_PAUSE[0], 1'b0);
`else
        mode = 2'd1;
        #1;
        chk("pause_latency", W_PLAY, 1'b0);
        step(1);
        chk("pause_static", W_PAUSE[0], 1'b0);
        step(30);
        chk("pause_no_scroll", W_PAUSE[0], 1'b0);
        mode = 2'd2;
        step(1);
        chk("hello_load", W_HELL, 1'b0);
        freeze = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step(1);
            chk("hello_static", W_HELL, 1'b0);
        end
        mode = 2'd3;
        step(1);
        chk("blank_freeze_ignored", W_BLNK, 1'b0);
        mode = 2'd2;
        step(1);
        chk("hello_reload", W_HELL, 1'b0);
        freeze = 1'b0;
        step(1);
        rst_n = 1'b0;
        #1;
        chk("async_reset", W_BLNK, 1'b0);
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("reset_reload", W_HELL, 1'b0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/marquee_ctrl.md
# marquee_ctrl

- Generates the four letter codes (BCD3..BCD0) consumed by the 7-segment scan driver.
- Selects one of three status messages from `mode`.
  - PLAY is shown statically.
  - PAUSE and HELLO scroll right-to-left through a 4-digit window at a fixed step rate.
- Sits between the player control FSM and the display driver.
- All outputs are registered.

## Interface
- `TICK_DIV`, default 25_000_000: clock cycles per scroll step (≥2).
- `clk  in  1`: system clock, all logic on rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `mode  in  2`: 0 = PLAY, 1 = PAUSE, 2 = HELLO, 3 = BLANK.
- `freeze  in  1`: while high, the scroll position and prescaler hold.
- `BCD3  out  4`: letter code for the leftmost digit.
- `BCD2  out  4`: letter code for the second digit.
- `BCD1  out  4`: letter code for the third digit.
- `BCD0  out  4`: letter code for the rightmost digit.
- `wrap  out  1`: one-cycle pulse when the scroll position returns to 0.

## Operation
- Letter codes: P=0, L=1, A=2, Y=3, U=4, S=5, E=6, H=7, O=8, blank=4'hF.
- Message buffers, 6 entries, index 0..5:
  - PAUSE = P A U S E _
  - HELLO = H E L L O _
  - PLAY = P L A Y _ _
  - BLANK = all _
- Window at position `pos`: BCD3 = buf[pos], BCD2 = buf[(pos+1)%6], BCD1 = buf[(pos+2)%6], BCD0 = buf[(pos+3)%6].
- States are derived from `mode_q`:
  - STATIC (PLAY, BLANK): `pos` is fixed at 0 and the prescaler `cnt` is fixed at 0.
  - SCROLL (PAUSE, HELLO): `cnt` counts 0..TICK_DIV-1.
    - At `cnt == TICK_DIV-1`: `cnt` goes to 0 and `pos` goes to (pos+1) mod 6.
- Per-edge priority, highest first:
  1. Mode change (`mode != mode_q`): `mode_q <= mode`, `pos <= 0`, `cnt <= 0`, outputs <= window(mode, 0). This overrides `freeze` and any pending step.
  2. `freeze` high: `cnt`, `pos` and the outputs all hold.
  3. Step: outputs <= window(mode_q, pos+1 mod 6).
     - `wrap` = 1 for that cycle iff the new `pos` == 0.
  4. Otherwise: `cnt` increments and the outputs hold.
- Example sequence, PAUSE: PAUS, AUSE, USE_, SE_P, E_PA, _PAU, then back to PAUS with `wrap`.

## Timing
- Reset values:
  - BCD3..BCD0 = 4'hF
  - `wrap` = 0
  - `pos` = 0
  - `cnt` = 0
  - `mode_q` = 3 (BLANK)
- Mode-to-output latency is 1 cycle: the outputs show the new message after the first edge that samples the changed `mode`.
- In steady SCROLL the outputs change every TICK_DIV cycles; the first step lands TICK_DIV edges after the mode-change edge.
- `wrap` is asserted on the same edge the outputs return to window 0. It is never asserted on a mode change or in STATIC.
- A reset assertion mid-scroll forces the reset values immediately. After release, the first edge loads the current `mode` at window 0.
- Releasing `freeze` resumes counting from the held `cnt`; the step timing is not restarted.

## Configuration
- `MARQUEE_SCROLL_EN` defined: behaviour is as described above.
- Not defined:
  - All modes are STATIC and the prescaler is removed.
  - PAUSE shows PAUS and HELLO shows HELL.
  - `wrap` is tied to 0 and `freeze` is ignored.
  - Mode-change latency stays at 1 cycle.

## Structure
- Shared package `marquee_pkg` holds:
  - the letter-code constants (P..O, BLANK = 4'hF);
  - the mode encodings;
  - `MSG_LEN` = 6 and `WIN_LEN` = 4.
- Sub-module `msg_rom`: combinational lookup of (mode, index 0..5) to a 4-bit letter code. It is instantiated four times, once per digit index; `marquee_ctrl` holds all state.

## Test plan
All scenarios use TICK_DIV=4.
- Reset release with `mode`=0: outputs are F,F,F,F during reset, then P,L,A,Y (0,1,2,3) one edge after release, with no further change over 50 cycles and `wrap` never asserted.
- Scroll: `mode`=1 → PAUS (0,2,4,5), then AUSE after 4 more edges, then one step every 4 cycles. After 24 cycles the outputs are back at PAUS with a single-cycle `wrap`.
- Freeze: assert `freeze` 2 cycles into the USE_ window for 10 cycles → outputs hold. The step to SE_P occurs exactly 2 cycles after release.
- Mode change mid-scroll: in window SE_P, set `mode`=2 on the same edge as a pending step → outputs show HELL (7,6,1,1), with no `wrap` and `cnt` restarted.
- Reset mid-scroll: assert `rst_n`=0 in window E_PA → all outputs read F immediately (asynchronously), and `wrap`=0.
- `MARQUEE_SCROLL_EN` undefined, `mode`=2 → outputs hold at HELL indefinitely and `wrap` stays 0.
